datapath_accum: RTL and testbench

DATAPATH_ACCUM -- requirements
Module: datapath_accum

---
 rtl/datapath_pkg.sv | 18 +
 rtl/datapath_accum_if.sv | 27 ++
 rtl/datapath_acc_add.sv | 28 ++
 rtl/datapath_accum.sv | 100 ++++++++++
 tb/tb_datapath_accum.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared types and default widths for the datapath accumulator slice.
package datapath_pkg;

  localparam int ACC_W_DEF = 8;
  localparam int SUM_W_DEF = 5;

  // One sample in flight: capture in IDLE, add in ACCUM, hold result in PRESENT.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic logic [3:0] cnt_inc(input logic [3:0] cnt);
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/datapath_accum_if.sv
// Upstream adder / downstream consumer bundle for datapath_accum.
interface datapath_accum_if #(
  parameter int ACC_W = datapath_pkg::ACC_W_DEF,
  parameter int SUM_W = datapath_pkg::SUM_W_DEF
);

  logic             load;
  logic [SUM_W-1:0] Q;
  logic             clr;
  logic             out_ready;
  logic             load_ready;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             ovf;
  logic [3:0]       sample_cnt;

  modport master (
    output load, Q, clr, out_ready,
    input  load_ready, acc, acc_valid, ovf, sample_cnt
  );

  modport slave (
    input  load, Q, clr, out_ready,
    output load_ready, acc, acc_valid, ovf, sample_cnt
  );

endinterface

// File: rtl/datapath_acc_add.sv
// Combinational acc + sum with overflow detect; DATAPATH_ACCUM_SAT_EN clamps to all-ones.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
module datapath_acc_add #(
  parameter int ACC_W = datapath_pkg::ACC_W_DEF,
  parameter int SUM_W = datapath_pkg::SUM_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [SUM_W-1:0] sum,
  output logic [ACC_W-1:0] acc_nxt,
  output logic             ovf
);

  localparam int W1 = ACC_W + 1;

  logic [ACC_W:0] raw;

  // One guard bit is enough: sum is never wider than the accumulator.
  assign raw = {1'b0, acc} + W1'(sum);
  assign ovf = raw[ACC_W];

`ifdef DATAPATH_ACCUM_SAT_EN
  assign acc_nxt = ovf ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign acc_nxt = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/datapath_accum.sv
// Accumulates upstream adder results, one sample in flight at a time.
// Latency: acc_valid rises 2 edges after a load transfer.
// Backpressure: result held in PRESENT until out_ready; load_ready low while busy.
module datapath_accum
  import datapath_pkg::*;
#(
  parameter int ACC_W = datapath_pkg::ACC_W_DEF,
  parameter int SUM_W = datapath_pkg::SUM_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  datapath_accum_if.slave bus
);

  state_t           state_q, state_nxt;
  logic [SUM_W-1:0] sum_reg, sum_nxt;
  logic [ACC_W-1:0] acc_q, acc_nxt, add_acc;
  logic             ovf_q, ovf_nxt, add_ovf;
  logic [3:0]       cnt_q, cnt_nxt;
  logic             idle;
  logic             xfer;

  assign idle = (state_q == IDLE);
  assign xfer = bus.load && idle;

  datapath_acc_add #(
    .ACC_W (ACC_W),
    .SUM_W (SUM_W)
  ) u_add (
    .acc     (acc_q),
    .sum     (sum_reg),
    .acc_nxt (add_acc),
    .ovf     (add_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sum_reg <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_nxt;
      sum_reg <= sum_nxt;
      acc_q   <= acc_nxt;
      ovf_q   <= ovf_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    sum_nxt   = sum_reg;
    acc_nxt   = acc_q;
    ovf_nxt   = ovf_q;
    cnt_nxt   = cnt_q;
    // clr wins over any concurrent load or out_ready.
    if (bus.clr) begin
      state_nxt = IDLE;
      sum_nxt   = '0;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            sum_nxt   = bus.Q;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          acc_nxt   = add_acc;
          ovf_nxt   = ovf_q | add_ovf;
          cnt_nxt   = cnt_inc(cnt_q);
          state_nxt = PRESENT;
        end
        PRESENT: begin
          if (bus.out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.load_ready = idle;
  assign bus.acc        = acc_q;
  assign bus.acc_valid  = (state_q == PRESENT);
  assign bus.ovf        = ovf_q;
  assign bus.sample_cnt = cnt_q;

  a_present_hold: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == PRESENT && !bus.out_ready && !bus.clr) |=> (state_q == PRESENT && $stable(acc_q))
  );

endmodule

// File: tb/tb_datapath_accum.sv
// Bench for datapath_accum: directed vector table, multi-cycle sequences, randomized run vs. arithmetic model.
module tb_datapath_accum;

  localparam int     ACC_W   = 8;
  localparam int     SUM_W   = 5;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

`ifdef DATAPATH_ACCUM_SAT_EN
  localparam longint EXP_ACC_9  = 255;
  localparam longint EXP_ACC_14 = 255;
`else
  localparam longint EXP_ACC_9  = 23;
  localparam longint EXP_ACC_14 = 178;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_accum_if #(.ACC_W(ACC_W), .SUM_W(SUM_W)) bus ();

  datapath_accum #(.ACC_W(ACC_W), .SUM_W(SUM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: running total of every accepted sample, folded to ACC_W only on output.
  longint m_total;
  int     m_n;
  int     m_since;   // -1 idle, 0 sample captured, 1 result presented
  int     m_pend;

  typedef struct {
    logic       load;
    logic [4:0] q;
    logic       clr;
    logic       out_ready;
    logic [7:0] acc;
    logic       valid;
    logic       lr;
    logic       ovf;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic ld, input logic [4:0] q, input logic c, input logic ordy,
                              input logic [7:0] a, input logic v, input logic lr, input logic o,
                              input logic [3:0] n);
    vec_t r;
    r.load = ld; r.q = q; r.clr = c; r.out_ready = ordy;
    r.acc = a; r.valid = v; r.lr = lr; r.ovf = o; r.cnt = n;
    return r;
  endfunction

  function automatic longint exp_acc(input longint total);
`ifdef DATAPATH_ACCUM_SAT_EN
    return (total > ACC_MAX) ? ACC_MAX : total;
`else
    return total % (ACC_MAX + 1);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_n = 0; m_since = -1; m_pend = 0;
  endtask

  task automatic model_edge();
    if (bus.clr) begin
      m_total = 0; m_n = 0; m_since = -1;
    end else if (m_since < 0) begin
      if (bus.load) begin
        m_pend  = int'(bus.Q);
        m_since = 0;
      end
    end else if (m_since == 0) begin
      m_total += m_pend;
      m_n++;
      m_since = 1;
    end else if (bus.out_ready) begin
      m_since = -1;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".acc"},   bus.acc,        exp_acc(m_total));
    chk({tag, ".valid"}, bus.acc_valid,  m_since >= 1);
    chk({tag, ".lr"},    bus.load_ready, m_since < 0);
    chk({tag, ".ovf"},   bus.ovf,        m_total > ACC_MAX);
    chk({tag, ".cnt"},   bus.sample_cnt, m_n % 16);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load = 1'b0; bus.Q = '0; bus.clr = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
  endtask

  task automatic txn(input logic [4:0] q, output int lat);
    int guard = 0;
    while (!bus.load_ready && guard < 20) begin
      cycle();
      guard++;
    end
    if (guard >= 20) chk("txn_ready_timeout", 0, 1);
    bus.load = 1'b1; bus.Q = q;
    cycle();
    bus.load = 1'b0;
    lat = 1;
    while (!bus.acc_valid && lat < 20) begin
      cycle();
      lat++;
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".acc"},   bus.acc,        0);
    chk({tag, ".valid"}, bus.acc_valid,  0);
    chk({tag, ".lr"},    bus.load_ready, 1);
    chk({tag, ".ovf"},   bus.ovf,        0);
    chk({tag, ".cnt"},   bus.sample_cnt, 0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Directed table: inputs applied for one edge, outputs checked just after it.
    vecs[0]  = mk(1, 5'd19, 0, 0,   0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 5'd0,  0, 0,  19, 1, 0, 0, 1);
    vecs[2]  = mk(0, 5'd0,  0, 0,  19, 1, 0, 0, 1);
    vecs[3]  = mk(1, 5'd7,  0, 0,  19, 1, 0, 0, 1);
    vecs[4]  = mk(0, 5'd0,  0, 0,  19, 1, 0, 0, 1);
    vecs[5]  = mk(1, 5'd3,  0, 0,  19, 1, 0, 0, 1);
    vecs[6]  = mk(0, 5'd0,  0, 0,  19, 1, 0, 0, 1);
    vecs[7]  = mk(0, 5'd0,  0, 1,  19, 0, 1, 0, 1);
    vecs[8]  = mk(1, 5'd7,  1, 0,   0, 0, 1, 0, 0);
    vecs[9]  = mk(0, 5'd0,  0, 0,   0, 0, 1, 0, 0);
    vecs[10] = mk(1, 5'd31, 0, 0,   0, 0, 0, 0, 0);
    vecs[11] = mk(0, 5'd0,  0, 0,  31, 1, 0, 0, 1);
    vecs[12] = mk(1, 5'd5,  0, 1,  31, 0, 1, 0, 1);
    vecs[13] = mk(0, 5'd0,  0, 1,  31, 0, 1, 0, 1);

    idle_inputs();
    model_reset();
    reset = 1'b1;
    #1;
    reset_checks("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      bus.load = vecs[i].load; bus.Q = vecs[i].q;
      bus.clr = vecs[i].clr; bus.out_ready = vecs[i].out_ready;
      cycle();
      chk($sformatf("vec%0d.acc", i),   bus.acc,        vecs[i].acc);
      chk($sformatf("vec%0d.valid", i), bus.acc_valid,  vecs[i].valid);
      chk($sformatf("vec%0d.lr", i),    bus.load_ready, vecs[i].lr);
      chk($sformatf("vec%0d.ovf", i),   bus.ovf,        vecs[i].ovf);
      chk($sformatf("vec%0d.cnt", i),   bus.sample_cnt, vecs[i].cnt);
    end
    idle_inputs();

    // Fourteen samples of 31: overflow first appears on the 9th (279).
    do_clr();
    for (int i = 1; i <= 14; i++) begin
      txn(5'd31, lat);
      chk($sformatf("ovf_seq%0d.latency", i), lat, 2);
      if (i == 8) begin
        chk("ovf_seq8.acc", bus.acc, 248);
        chk("ovf_seq8.ovf", bus.ovf, 0);
      end
      if (i == 9) begin
        chk("ovf_seq9.acc", bus.acc, EXP_ACC_9);
        chk("ovf_seq9.ovf", bus.ovf, 1);
      end
    end
    chk("ovf_seq14.acc", bus.acc, EXP_ACC_14);
    chk("ovf_seq14.ovf", bus.ovf, 1);
    chk("ovf_seq14.cnt", bus.sample_cnt, 14);

    // Seventeen unit samples: count wraps past 15.
    do_clr();
    for (int i = 0; i < 17; i++) txn(5'd1, lat);
    chk("wrap.cnt", bus.sample_cnt, 1);
    chk("wrap.acc", bus.acc, 17);
    chk("wrap.ovf", bus.ovf, 0);

    // Asynchronous reset while a sample sits in ACCUM.
    do_clr();
    txn(5'd20, lat);
    bus.load = 1'b1; bus.Q = 5'd9;
    cycle();
    bus.load = 1'b0;
    chk("areset.pre_acc", bus.acc, 20);
    chk("areset.pre_lr", bus.load_ready, 0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    reset_checks("areset.now");
    @(posedge clk);
    #2;
    reset_checks("areset.held");
    reset = 1'b0;
    txn(5'd6, lat);
    chk("areset.post_latency", lat, 2);
    chk("areset.post_acc", bus.acc, 6);
    chk("areset.post_cnt", bus.sample_cnt, 1);

    // Randomized traffic against the model.
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.load      = $urandom_range(0, 1) == 1;
      bus.Q         = SUM_W'($urandom_range(0, 31));
      bus.clr       = $urandom_range(0, 40) == 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      cycle();
      model_check("rnd");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
